// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 2-cycle pipelined memory port between the
// instruction fetch path and the data load/store path. Data normally wins;
// a streak counter hands the port to a waiting fetch after MAX_STREAK
// consecutive data wins. Each accepted access carries a small owner tag
// down a two-entry pipeline so the returning data reaches the requester
// that issued it. Fetch accesses caught by a flush are dropped on return.
module mem_port_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    // The tag pipeline depth is hard-wired to the memory read latency.
    generate
        if (LATENCY != 2) begin : g_latency_check
            $error("mem_port_arbiter: LATENCY must be 2");
        end
    endgenerate

    localparam int STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef struct packed {
        logic valid;
        logic owner;   // 0 = fetch, 1 = data
        logic kill;
    } tag_t;

    tag_t                tag_p1;
    tag_t                tag_p2;
    tag_t                tag_p2_next;
    logic [STREAK_W-1:0] streak;
    logic                streak_at_max;
    logic                fetch_win;
    logic                gnt_any;

    // Arbitration: data first, unless fetch is alone or has waited out the streak.
    always_comb begin
        streak_at_max = (MAX_STREAK != 0) && (streak == STREAK_MAX);
        fetch_win     = clk_en && if_req && !if_flush && (!d_req || streak_at_max);
        if_gnt        = fetch_win;
        d_gnt         = clk_en && d_req && !fetch_win;
        gnt_any       = if_gnt || d_gnt;
    end

    // Memory command follows whichever requester holds the grant; idle otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_ren  = 1'b1;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_ren   = (d_we == 4'h0);
            mem_wen   = d_we;
            mem_wdata = d_wdata;
        end
    end

    // A flush marks any fetch entry as killed while it moves down the pipe.
    always_comb begin
        tag_p2_next = tag_p1;
        if (if_flush && !tag_p1.owner) begin
            tag_p2_next.kill = 1'b1;
        end
    end

    // Tag pipeline: a new tag enters stage 1, stage 1 advances to stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_p1 <= '0;
            tag_p2 <= '0;
        end else if (clk_en) begin
            tag_p1 <= '{valid: gnt_any, owner: d_gnt, kill: 1'b0};
            tag_p2 <= tag_p2_next;
        end
    end

    // Streak of data wins while fetch waits; cleared once fetch wins or stops asking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (clk_en) begin
            if (MAX_STREAK == 0 || if_gnt || !if_req || if_flush) begin
                streak <= '0;
            end else if (d_gnt && streak != STREAK_MAX) begin
                streak <= streak + STREAK_ONE;
            end
        end
    end

    // Return routing from the stage-2 tag; read data is zeroed when not valid.
    always_comb begin
        if_rvalid = clk_en && tag_p2.valid && !tag_p2.owner && !tag_p2.kill;
        d_rvalid  = clk_en && tag_p2.valid && tag_p2.owner;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = tag_p1.valid || tag_p2.valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the
// accesses in flight.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(.MAX_STREAK(MAXS), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each accepted access with its owner, kill flag and
    // the number of enabled edges it has seen since acceptance.
    typedef struct {
        bit owner;
        bit kill;
        int age;
    } ent_t;
    ent_t q[$];
    int   streak_m;

    logic        cap_if_gnt, cap_d_gnt, cap_if_rvalid, cap_d_rvalid;
    logic [31:0] cap_if_rdata;
    logic [3:0]  cap_mem_wen;
    logic        dg_hist[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, then advance the model across the rising edge.
    task automatic cyc(input bit en, input bit ifr, input logic [31:0] ia, input bit fl,
                       input bit dr, input logic [31:0] da, input logic [3:0] we,
                       input logic [31:0] wd, input logic [31:0] rd);
        bit   e_if, e_d, e_irv, e_drv;
        ent_t nq[$];
        @(negedge clk);
        clk_en = en; if_req = ifr; if_addr = ia; if_flush = fl;
        d_req = dr; d_addr = da; d_we = we; d_wdata = wd; mem_rdata = rd;
        #1;
        e_if = 0; e_d = 0; e_irv = 0; e_drv = 0;
        if (en) begin
            if (ifr && !fl && (!dr || (MAXS != 0 && streak_m == MAXS))) e_if = 1;
            else if (dr) e_d = 1;
            foreach (q[i]) begin
                if (q[i].age == 2) begin
                    if (q[i].owner) e_drv = 1;
                    else if (!q[i].kill) e_irv = 1;
                end
            end
        end
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        chk("mem_ren", mem_ren, e_if ? 1 : (e_d ? (we == 4'h0) : 0));
        chk("mem_wen", mem_wen, e_d ? we : 4'h0);
        if (en) begin
            chk("mem_addr", mem_addr, e_if ? ia : (e_d ? da : 32'h0));
            chk("mem_wdata", mem_wdata, e_d ? wd : 32'h0);
            chk("busy", busy, q.size() != 0);
        end
        chk("if_rvalid", if_rvalid, e_irv);
        chk("if_rdata", if_rdata, e_irv ? rd : 32'h0);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("d_rdata", d_rdata, e_drv ? rd : 32'h0);
        cap_if_gnt = if_gnt; cap_d_gnt = d_gnt; cap_if_rvalid = if_rvalid;
        cap_d_rvalid = d_rvalid; cap_if_rdata = if_rdata; cap_mem_wen = mem_wen;
        @(posedge clk);
        if (!rst && en) begin
            foreach (q[i]) begin
                if (q[i].age < 2) begin
                    ent_t t;
                    t = q[i];
                    t.age = 2;
                    if (fl && !t.owner) t.kill = 1;
                    nq.push_back(t);
                end
            end
            if (e_if || e_d) nq.push_back('{owner: e_d, kill: 1'b0, age: 1});
            q = nq;
            if (e_if || !ifr || fl) streak_m = 0;
            else if (e_d && streak_m < MAXS) streak_m++;
        end
    endtask

    task automatic idle();
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_addr = '0; d_we = '0; d_wdata = '0; mem_rdata = '0;
        streak_m = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-access: data read accepted with fetch waiting, then reset.
        cyc(1, 1, 32'h80, 0, 1, 32'h2000, 4'h0, 32'h0, 32'h0);
        chk("pre_rst_d_gnt", cap_d_gnt, 1);
        @(negedge clk);
        clk_en = 1; if_req = 0; d_req = 0;
        #1;
        chk("pre_rst_busy", busy, 1);
        #1;
        rst = 1'b1;
        q.delete();
        streak_m = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_d_rvalid", d_rvalid, 0);
        chk("mid_rst_if_rvalid", if_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("post_rst_d_rvalid", cap_d_rvalid, 0);

        // Both requesting continuously: four data wins, then fetch, then data.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 32'h100 + i, 0, 1, 32'h3000 + i, 4'h0, 32'h0, $urandom);
            dg_hist[i] = cap_d_gnt;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("streak_dgnt%0d", i), dg_hist[i], (i != 4));
        idle(); idle(); idle();

        // Lone fetch read returns two cycles later.
        cyc(1, 1, 32'h400, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("fetch_gnt", cap_if_gnt, 1);
        idle();
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
        chk("fetch_rvalid", cap_if_rvalid, 1);
        chk("fetch_rdata", cap_if_rdata, 32'hDEADBEEF);
        chk("fetch_no_drvalid", cap_d_rvalid, 0);

        // Full-word store beats a concurrent fetch; ack two cycles later.
        cyc(1, 1, 32'h500, 0, 1, 32'h1000, 4'hF, 32'h12345678, 32'h0);
        chk("store_d_gnt", cap_d_gnt, 1);
        chk("store_if_gnt", cap_if_gnt, 0);
        chk("store_wen", cap_mem_wen, 4'hF);
        idle();
        idle();
        chk("store_ack", cap_d_rvalid, 1);

        // Flush kills the in-flight fetch and blocks the simultaneous one.
        idle();
        cyc(1, 1, 32'h600, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("flush_first_gnt", cap_if_gnt, 1);
        cyc(1, 1, 32'h604, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("flush_blocks_gnt", cap_if_gnt, 0);
        idle();
        chk("flush_no_rv_c2", cap_if_rvalid, 0);
        idle();
        chk("flush_no_rv_c3", cap_if_rvalid, 0);

        // Clock enable low stalls an in-flight fetch.
        cyc(1, 1, 32'h700, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("stall_gnt", cap_if_gnt, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h704, 0, 1, 32'h0, 4'h0, 32'h0, 32'hCAFE0000);
            chk($sformatf("stall_rv%0d", i), cap_if_rvalid, 0);
        end
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'hCAFE0001);
        chk("stall_rv_en1", cap_if_rvalid, 0);
        cyc(1, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'hCAFE0002);
        chk("stall_rv_en2", cap_if_rvalid, 1);
        chk("stall_rdata", cap_if_rdata, 32'hCAFE0002);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit          en, ifr, fl, dr;
            logic [3:0]  we;
            en  = ($urandom_range(0, 99) < 85);
            ifr = ($urandom_range(0, 99) < 60);
            fl  = ($urandom_range(0, 99) < 10);
            dr  = ($urandom_range(0, 99) < 55);
            we  = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            cyc(en, ifr, $urandom, fl, dr, $urandom, we, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
